// File: rtl/pc_pkg.sv
// Shared definitions for the cpu-16 program-counter unit: op codes, default
// width and the wrapped +/-1 helper used by the next-PC logic.
package pc_pkg;

    localparam int PC_W_DEFAULT = 8;
    localparam int SEQ_W        = 16;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_INC  = 3'd1;
    localparam logic [2:0] OP_DEC  = 3'd2;
    localparam logic [2:0] OP_JMP  = 3'd3;
    localparam logic [2:0] OP_BR   = 3'd4;
    localparam logic [2:0] OP_CALL = 3'd5;
    localparam logic [2:0] OP_RET  = 3'd6;
    localparam logic [2:0] OP_RST  = 3'd7;

    // Works on the widest PC; callers truncate to W bits, which gives mod 2^W.
    function automatic logic [SEQ_W-1:0] pc_next_seq(input logic [SEQ_W-1:0] pc,
                                                     input logic inc);
        logic [SEQ_W-1:0] res;
        if (inc) begin
            res = pc + 16'd1;
        end else begin
            res = pc - 16'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pc_branch_unit_ret_stack.sv
// LIFO return-address stack: synchronous push, combinational read of the top
// entry. Push when full and pop when empty are ignored.
module ret_stack
    import pc_pkg::*;
#(
    parameter int  W     = PC_W_DEFAULT,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int SPW   = AW + 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           push,
    input  logic           pop,
    input  logic [W-1:0]   din,
    output logic [W-1:0]   dout,
    output logic [SPW-1:0] sp,
    output logic           full,
    output logic           empty
);

    logic [W-1:0]   r_mem [DEPTH];
    logic [SPW-1:0] r_sp;
    logic [AW-1:0]  w_wr_idx;
    logic [AW-1:0]  w_top_idx;
    logic           w_push_ok;
    logic           w_pop_ok;

    // With DEPTH a power of two, sp==DEPTH aliases to index 0, so top = idx-1 still holds.
    assign w_wr_idx  = r_sp[AW-1:0];
    assign w_top_idx = w_wr_idx - AW'(1);
    assign full      = (r_sp == SPW'(DEPTH));
    assign empty     = (r_sp == {SPW{1'b0}});
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign dout      = r_mem[w_top_idx];
    assign sp        = r_sp;

    // Stack pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sp <= {SPW{1'b0}};
        end else if (w_push_ok) begin
            r_sp <= r_sp + SPW'(1);
        end else if (w_pop_ok) begin
            r_sp <= r_sp - SPW'(1);
        end else begin
            r_sp <= r_sp;
        end
    end

    // Entry storage; contents are don't-care after reset
    always_ff @(posedge clock) begin
        if (w_push_ok && !reset) begin
            r_mem[w_wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with conditional absolute/relative branches, call/return via
// ret_stack, and sticky overflow/underflow faults. All outputs registered.
module pc_branch_unit
    import pc_pkg::*;
#(
    parameter int          W         = PC_W_DEFAULT,
    parameter int          DEPTH     = 4,
    parameter logic [W-1:0] RESET_VEC = {W{1'b0}},
    localparam int         SPW       = $clog2(DEPTH) + 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           en,
    input  logic [2:0]     op,
    input  logic           cond,
    input  logic [W-1:0]   target,
    input  logic [W-1:0]   offset,
    output logic [W-1:0]   pc,
    output logic [SPW-1:0] sp,
    output logic           stack_full,
    output logic           stack_empty,
    output logic           ovf,
    output logic           unf
);

    logic [W-1:0]     r_pc;
    logic             r_ovf;
    logic             r_unf;
    logic [W-1:0]     w_pc_nxt;
    logic             w_ovf_nxt;
    logic             w_unf_nxt;
    logic             w_push;
    logic             w_pop;
    logic [SEQ_W-1:0] w_pc_ext;
    logic [W-1:0]     w_pc_inc;
    logic [W-1:0]     w_pc_dec;
    logic [W-1:0]     w_top;
    logic             w_full;
    logic             w_empty;

    ret_stack #(.W(W), .DEPTH(DEPTH)) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .dout  (w_top),
        .sp    (sp),
        .full  (w_full),
        .empty (w_empty)
    );

    // Zero-extend the PC into the helper's fixed width
    always_comb begin
        w_pc_ext         = {SEQ_W{1'b0}};
        w_pc_ext[W-1:0]  = r_pc;
    end

    assign w_pc_inc = W'(pc_next_seq(w_pc_ext, 1'b1));
    assign w_pc_dec = W'(pc_next_seq(w_pc_ext, 1'b0));

    // Op decode and next-PC / fault-flag selection
    always_comb begin
        w_pc_nxt  = r_pc;
        w_ovf_nxt = r_ovf;
        w_unf_nxt = r_unf;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        if (en) begin
            case (op)
                OP_HOLD: w_pc_nxt = r_pc;
                OP_INC:  w_pc_nxt = w_pc_inc;
                OP_DEC:  w_pc_nxt = w_pc_dec;
                OP_JMP:  w_pc_nxt = cond ? target : w_pc_inc;
                OP_BR:   w_pc_nxt = cond ? (r_pc + offset) : w_pc_inc;
                OP_CALL: begin
                    if (w_full) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_push   = 1'b1;
                        w_pc_nxt = target;
                    end
                end
                OP_RET: begin
                    if (w_empty) begin
                        w_unf_nxt = 1'b1;
                    end else begin
                        w_pop    = 1'b1;
                        w_pc_nxt = w_top;
                    end
                end
                OP_RST: begin
                    w_pc_nxt  = RESET_VEC;
                    w_ovf_nxt = 1'b0;
                    w_unf_nxt = 1'b0;
                end
                default: w_pc_nxt = r_pc;
            endcase
        end else begin
            w_pc_nxt = r_pc;
        end
    end

    // PC and sticky fault registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc  <= RESET_VEC;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_ovf <= w_ovf_nxt;
            r_unf <= w_unf_nxt;
        end
    end

    assign pc          = r_pc;
    assign ovf         = r_ovf;
    assign unf         = r_unf;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed walk through the main
// behaviours with literal expectations, then random ops against a queue model.
module tb_pc_branch_unit;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int SPW   = $clog2(DEPTH) + 1;
    localparam int MOD   = 1 << W;
    localparam int RVEC  = 0;

    logic           clock  = 1'b0;
    logic           reset  = 1'b0;
    logic           en     = 1'b0;
    logic [2:0]     op     = 3'd0;
    logic           cond   = 1'b0;
    logic [W-1:0]   target = '0;
    logic [W-1:0]   offset = '0;
    logic [W-1:0]   pc;
    logic [SPW-1:0] sp;
    logic           stack_full;
    logic           stack_empty;
    logic           ovf;
    logic           unf;

    int n_chk = 0;
    int n_err = 0;
    bit checking = 1'b0;

    int m_pc  = 0;
    int m_ovf = 0;
    int m_unf = 0;
    int m_stk[$];

    pc_branch_unit #(.W(W), .DEPTH(DEPTH), .RESET_VEC(RVEC[W-1:0])) dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .op          (op),
        .cond        (cond),
        .target      (target),
        .offset      (offset),
        .pc          (pc),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf         (ovf),
        .unf         (unf)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies each sampled op in plain integer arithmetic
    always @(posedge clock) begin
        if (reset) begin
            m_pc = RVEC;
            m_ovf = 0;
            m_unf = 0;
            m_stk.delete();
        end else if (en) begin
            case (op)
                3'd1: m_pc = (m_pc + 1) % MOD;
                3'd2: m_pc = (m_pc + MOD - 1) % MOD;
                3'd3: m_pc = cond ? int'(target) : (m_pc + 1) % MOD;
                3'd4: m_pc = cond ? (m_pc + int'(offset)) % MOD : (m_pc + 1) % MOD;
                3'd5: begin
                    if (m_stk.size() == DEPTH) m_ovf = 1;
                    else begin
                        m_stk.push_back((m_pc + 1) % MOD);
                        m_pc = int'(target);
                    end
                end
                3'd6: begin
                    if (m_stk.size() == 0) m_unf = 1;
                    else m_pc = m_stk.pop_back();
                end
                3'd7: begin
                    m_pc = RVEC;
                    m_ovf = 0;
                    m_unf = 0;
                end
                default: ;
            endcase
        end
    end

    // Compare every output against the model midway through each cycle
    always @(negedge clock) begin
        if (checking) begin
            chk("pc", int'(pc), m_pc);
            chk("sp", int'(sp), m_stk.size());
            chk("stack_full", int'(stack_full), int'(m_stk.size() == DEPTH));
            chk("stack_empty", int'(stack_empty), int'(m_stk.size() == 0));
            chk("ovf", int'(ovf), m_ovf);
            chk("unf", int'(unf), m_unf);
        end
    end

    // Present one cycle of inputs, let it be sampled, then return to idle
    task automatic drive(input logic r, input logic e, input logic [2:0] o,
                         input logic c, input int t, input int off);
        reset  = r;
        en     = e;
        op     = o;
        cond   = c;
        target = t[W-1:0];
        offset = off[W-1:0];
        @(posedge clock);
        #2;
        reset = 1'b0;
        en    = 1'b0;
        op    = 3'd0;
    endtask

    task automatic run(input logic [2:0] o, input logic c, input int t, input int off);
        drive(1'b0, 1'b1, o, c, t, off);
    endtask

    initial begin
        drive(1'b1, 1'b0, 3'd0, 1'b0, 0, 0);
        checking = 1'b1;
        chk("lit_reset_pc", int'(pc), 0);
        chk("lit_reset_empty", int'(stack_empty), 1);

        repeat (3) run(3'd1, 1'b0, 0, 0);
        chk("lit_inc3", int'(pc), 3);
        repeat (4) run(3'd2, 1'b0, 0, 0);
        chk("lit_dec_wrap", int'(pc), 8'hFF);

        run(3'd3, 1'b1, 8'hF0, 0);
        run(3'd4, 1'b1, 0, 8'h20);
        chk("lit_br_wrap", int'(pc), 8'h10);
        run(3'd4, 1'b1, 0, 8'hFE);
        chk("lit_br_neg", int'(pc), 8'h0E);
        run(3'd4, 1'b0, 0, 8'h40);
        chk("lit_br_nc", int'(pc), 8'h0F);

        run(3'd3, 1'b1, 8'h7A, 0);
        chk("lit_jmp", int'(pc), 8'h7A);
        run(3'd3, 1'b0, 8'h7A, 0);
        chk("lit_jmp_nc", int'(pc), 8'h7B);
        repeat (5) drive(1'b0, 1'b0, 3'd1, 1'b1, 0, 0);
        chk("lit_hold_en0", int'(pc), 8'h7B);

        run(3'd3, 1'b1, 8'h10, 0);
        run(3'd5, 1'b0, 8'h20, 0);
        run(3'd5, 1'b0, 8'h30, 0);
        run(3'd5, 1'b0, 8'h40, 0);
        run(3'd5, 1'b0, 8'h50, 0);
        chk("lit_call_sp", int'(sp), 4);
        chk("lit_call_full", int'(stack_full), 1);
        run(3'd5, 1'b0, 8'h60, 0);
        chk("lit_ovf_pc", int'(pc), 8'h50);
        chk("lit_ovf", int'(ovf), 1);
        run(3'd6, 1'b0, 0, 0);
        chk("lit_ret1", int'(pc), 8'h41);
        run(3'd6, 1'b0, 0, 0);
        chk("lit_ret2", int'(pc), 8'h31);
        run(3'd6, 1'b0, 0, 0);
        chk("lit_ret3", int'(pc), 8'h21);
        run(3'd6, 1'b0, 0, 0);
        chk("lit_ret4", int'(pc), 8'h11);
        chk("lit_ret_empty", int'(stack_empty), 1);

        run(3'd6, 1'b0, 0, 0);
        chk("lit_unf_pc", int'(pc), 8'h11);
        chk("lit_unf", int'(unf), 1);
        run(3'd7, 1'b0, 0, 0);
        chk("lit_rst_pc", int'(pc), RVEC);
        chk("lit_rst_flags", int'({ovf, unf}), 0);

        run(3'd5, 1'b0, 8'h20, 0);
        run(3'd5, 1'b0, 8'h30, 0);
        run(3'd7, 1'b0, 0, 0);
        chk("lit_rst_keeps_sp", int'(sp), 2);
        drive(1'b1, 1'b1, 3'd5, 1'b0, 8'h99, 0);
        chk("lit_reset_call_pc", int'(pc), RVEC);
        chk("lit_reset_call_sp", int'(sp), 0);
        run(3'd6, 1'b0, 0, 0);
        chk("lit_reset_no_push", int'(unf), 1);

        // Random op stream, full rate, with occasional holds and resets
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)));
        end

        @(negedge clock);
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
